// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command front end.
//   - opcode encodings understood by the registered ALU
//   - issue FSM state type
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;  // low N bits of the product
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_ROL = 3'd6;
    localparam logic [2:0] OP_ROR = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO holding ALU commands.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (empties the FIFO)
//   push, wr_data     write one entry (ignored when full)
//   pop, rd_data      rd_data is the head entry; pop removes it (ignored when empty)
//   count             number of stored entries, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap on overflow.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               wr_data,
    input  logic                       pop,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign rd_data = mem[rd_ptr];

    // Storage needs no reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: command front end for the registered ALU.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   cmd_valid/cmd_ready           command handshake; cmd_a, cmd_b, cmd_op payload
//   alu_a, alu_b, alu_instruction operands to the ALU (held between operations)
//   alu_result                    ALU output, valid one cycle after issue
//   res_valid/res_ready           result handshake; res_data, res_op, res_err payload
// Each command spends ISSUE (ALU samples) then WAIT (result valid) before
// being captured, so back-to-back throughput is one result per 3 cycles.
module alu_issue
    import alu_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic [2:0]   cmd_op,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_instruction,
    input  logic [N-1:0] alu_result,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic [2:0]   res_op,
    output logic         res_err
);

    localparam int W  = 2 * N + 3;
    localparam int CW = $clog2(DEPTH + 1);

    state_t        state;
    logic [CW-1:0] fifo_count;
    logic [W-1:0]  head;
    logic          fifo_empty;
    logic          pop;
    logic [N-1:0]  head_a;
    logic [N-1:0]  head_b;
    logic [2:0]    head_op;
    logic [2:0]    sh_op;
    logic          sh_err;

    assign {head_op, head_b, head_a} = head;
    assign fifo_empty = (fifo_count == '0);

    // Space is judged on the registered count only: a same-cycle pop does
    // not make room for a push.
    assign cmd_ready = rst_n && (fifo_count != CW'(DEPTH));

    // Pop from IDLE, or straight out of DONE when the result is taken.
    assign pop = rst_n && !fifo_empty &&
                 ((state == IDLE) || ((state == DONE) && res_ready));

    alu_cmd_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_valid && cmd_ready),
        .wr_data ({cmd_op, cmd_b, cmd_a}),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            alu_a           <= '0;
            alu_b           <= '0;
            alu_instruction <= '0;
            sh_op           <= '0;
            sh_err          <= 1'b0;
            res_valid       <= 1'b0;
            res_data        <= '0;
            res_op          <= '0;
            res_err         <= 1'b0;
        end else begin
            if (pop) begin
                alu_a           <= head_a;
                alu_b           <= head_b;
                alu_instruction <= head_op;
                sh_op           <= head_op;
                sh_err          <= (head_op == OP_DIV) && (head_b == '0);
            end
            unique case (state)
                IDLE:  if (pop) state <= ISSUE;
                ISSUE: state <= WAIT;
                WAIT: begin
                    // Divide by zero overrides whatever the ALU produced.
                    res_data  <= sh_err ? '1 : alu_result;
                    res_op    <= sh_op;
                    res_err   <= sh_err;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= pop ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_instruction;
    logic [7:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_op;
    logic       res_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue #(.N(8), .DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_a           (cmd_a),
        .cmd_b           (cmd_b),
        .cmd_op          (cmd_op),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_instruction (alu_instruction),
        .alu_result      (alu_result),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .res_op          (res_op),
        .res_err         (res_err)
    );

    // Registered ALU; divide by zero returns junk the DUT must ignore.
    always @(posedge clk) begin
        case (alu_instruction)
            OP_ADD:  alu_result <= alu_a + alu_b;
            OP_SUB:  alu_result <= alu_a - alu_b;
            OP_MUL:  alu_result <= alu_a * alu_b;
            OP_DIV:  alu_result <= (alu_b == 8'h00) ? 8'h5A : alu_a / alu_b;
            OP_SHL:  alu_result <= alu_a << 1;
            OP_SHR:  alu_result <= alu_a >> 1;
            OP_ROL:  alu_result <= {alu_a[6:0], alu_a[7]};
            default: alu_result <= {alu_a[0], alu_a[7:1]};
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Sends one command and returns the result it produced (bounded waits).
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                           output logic [7:0] d, output logic [2:0] o, output logic e,
                           output bit ok);
        ok = 1'b0;
        d = 'x; o = 'x; e = 'x;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
        if (!res_valid) return;
        d = res_data; o = res_op; e = res_err;
        ok = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; res_ready = 1'b0;
        cmd_valid = 1'b1; cmd_a = 8'h11; cmd_b = 8'h22; cmd_op = OP_ADD;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (cmd_ready !== 1'b0) begin
                errors++; $display("FAIL reset_cmd_ready got %b want 0", cmd_ready);
            end
            checks++;
            if ({res_valid, res_data, res_op, res_err, alu_a, alu_b, alu_instruction} !== '0) begin
                errors++;
                $display("FAIL reset_outputs got rv=%b rd=%h ro=%h re=%b a=%h b=%h i=%h want all 0",
                         res_valid, res_data, res_op, res_err, alu_a, alu_b, alu_instruction);
            end
        end
        rst_n = 1'b1; cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL release_cmd_ready got %b want 1", cmd_ready);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || alu_instruction !== 3'd0 || dut.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_nothing_pushed got rv=%b instr=%h count=%0d want 0 0 0",
                     res_valid, alu_instruction, dut.fifo_count);
        end
    endtask

    task automatic test_single_add;
        cmd_valid = 1'b1; cmd_a = 8'h05; cmd_b = 8'h03; cmd_op = OP_ADD;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL add_accept got %b want 1", cmd_ready);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (c == 2) begin
                checks++;
                if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_instruction !== OP_ADD) begin
                    errors++;
                    $display("FAIL add_issue got a=%h b=%h i=%h want 05 03 0", alu_a, alu_b, alu_instruction);
                end
            end
            if (c < 4) begin
                checks++;
                if (res_valid !== 1'b0) begin
                    errors++; $display("FAIL add_early_valid cycle %0d got %b want 0", c, res_valid);
                end
            end
        end
        checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h08 || res_op !== OP_ADD || res_err !== 1'b0) begin
            errors++;
            $display("FAIL add_result got v=%b d=%h o=%h e=%b want 1 08 0 0", res_valid, res_data, res_op, res_err);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL add_consumed got %b want 0", res_valid);
        end
    endtask

    task automatic test_backpressure;
        int acc = 0;
        int got = 0;
        int last = 0;
        res_ready = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            cmd_valid = 1'b1;
            cmd_a = 8'h20 + 8'(acc); cmd_b = 8'h01; cmd_op = OP_ADD;
            if (cmd_valid && cmd_ready) acc++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (acc !== 5) begin
            errors++; $display("FAIL bp_accepted got %0d want 5", acc);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full_ready got %b want 0", cmd_ready);
        end
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            if (res_valid) begin
                checks++;
                if (res_data !== 8'h21 + 8'(got)) begin
                    errors++; $display("FAIL bp_order idx %0d got %h want %h", got, res_data, 8'h21 + 8'(got));
                end
                if (got > 0) begin
                    checks++;
                    if (cyc - last !== 3) begin
                        errors++; $display("FAIL bp_spacing idx %0d got %0d want 3", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            @(negedge clk);
        end
        res_ready = 1'b0;
        checks++;
        if (got !== 5) begin
            errors++; $display("FAIL bp_count got %0d want 5", got);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL bp_drained got rv=%b rdy=%b want 0 1", res_valid, cmd_ready);
        end
    endtask

    task automatic test_divide;
        logic [7:0] d; logic [2:0] o; logic e; bit ok;
        run_cmd(8'h10, 8'h00, OP_DIV, d, o, e, ok);
        checks++;
        if (!ok || d !== 8'hFF || e !== 1'b1 || o !== OP_DIV) begin
            errors++; $display("FAIL div_zero got ok=%b d=%h e=%b o=%h want 1 ff 1 3", ok, d, e, o);
        end
        run_cmd(8'h10, 8'h04, OP_DIV, d, o, e, ok);
        checks++;
        if (!ok || d !== 8'h04 || e !== 1'b0 || o !== OP_DIV) begin
            errors++; $display("FAIL div_normal got ok=%b d=%h e=%b o=%h want 1 04 0 3", ok, d, e, o);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] va [4] = '{8'h81, 8'h01, 8'h10, 8'h00};
        logic [7:0] vb [4] = '{8'h00, 8'h00, 8'h10, 8'h01};
        logic [2:0] vo [4] = '{OP_ROL, OP_ROR, OP_MUL, OP_SUB};
        logic [7:0] ve [4] = '{8'h03, 8'h80, 8'h00, 8'hFF};
        logic [7:0] d; logic [2:0] o; logic e; bit ok;
        for (int i = 0; i < 4; i++) begin
            run_cmd(va[i], vb[i], vo[i], d, o, e, ok);
            checks++;
            if (!ok || d !== ve[i] || o !== vo[i] || e !== 1'b0) begin
                errors++;
                $display("FAIL wrap_%0d got ok=%b d=%h o=%h e=%b want 1 %h %h 0", i, ok, d, o, e, ve[i], vo[i]);
            end
        end
    endtask

    task automatic test_reset_wait;
        bit seen = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cmd_valid = 1'b1; cmd_a = 8'h30 + 8'(c); cmd_b = 8'h02; cmd_op = OP_SUB;
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++; $display("FAIL rw_accept_%0d got %b want 1", c, cmd_ready);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        // Cycle 3: first command sits in WAIT, two more queued.
        checks++;
        if (res_valid !== 1'b0 || alu_a !== 8'h30 || dut.fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL rw_in_wait got rv=%b a=%h count=%0d want 0 30 2", res_valid, alu_a, dut.fifo_count);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || dut.fifo_count !== 3'd0) begin
            errors++; $display("FAIL rw_after_reset got rv=%b count=%0d want 0 0", res_valid, dut.fifo_count);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        res_ready = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rw_no_result got %b want 0", seen);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; res_ready = 1'b0;
        test_reset();
        test_single_add();
        test_backpressure();
        test_divide();
        test_wrap();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
